route_compute_unit: RTL and testbench
=====================================

// Module: route_compute_unit
// PURPOSE
//  Input-port stage directly downstream of circular_buffer. Inspects the head flit at the
//  buffer output, computes the XY (dimension-order) output port, and requests that port
//  from the switch allocator. Once granted, it pops and forwards flits to the crossbar
//  until the tail. One instance per input port.
// PARAMETERS
//  FLIT_SIZE  16  flit width in bits; [FLIT_SIZE-1:FLIT_SIZE-2] = flit type
//  COORD_W    2   width of each destination coordinate field
//  CUR_X      0   X coordinate of this router
//  CUR_Y      0   Y coordinate of this router
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          asynchronous, active-low reset
//  data_i       in   FLIT_SIZE  head flit from circular_buffer data_o (show-ahead, valid when !empty_i)
//  empty_i      in   1          circular_buffer empty_o
//  read_o       out  1          pop strobe to circular_buffer read_i (combinational)
//  req_o        out  5          one-hot port request {LOCAL,WEST,SOUTH,EAST,NORTH}
//  grant_i      in   1          switch allocator grant for req_o, held high for whole packet
//  out_ready_i  in   1          crossbar/downstream can accept a flit this cycle
//  flit_o       out  FLIT_SIZE  flit to crossbar
//  valid_o      out  1          flit_o valid this cycle
//  err_o        out  1          one-cycle pulse: non-head flit found in IDLE and dropped
// BEHAVIOUR
//  Flit types: 01 HEAD, 00 BODY, 10 TAIL, 11 HEAD_TAIL (single-flit packet).
//  Head fields: dest_x = data_i[FLIT_SIZE-3 -: COORD_W]; dest_y = next COORD_W bits below.
//  Routing (X first): dest_x>CUR_X -> EAST; dest_x<CUR_X -> WEST; else dest_y>CUR_Y -> NORTH;
//   dest_y<CUR_Y -> SOUTH; else LOCAL. Unsigned compares. Route latched in a 5-bit register.
//  Reset (rst=0, async): state=IDLE, route reg=0, req_o=0, err_o=0; read_o/valid_o=0, flit_o=0.
//  FSM states:
//   IDLE: if !empty_i and type in {HEAD,HEAD_TAIL}: latch route, go REQ; head NOT popped.
//         if !empty_i and type in {BODY,TAIL}: read_o=1 (drop), err_o=1 next cycle, stay IDLE.
//         req_o=0 in IDLE.
//   REQ:  req_o=route reg; on grant_i=1 go FWD next cycle. No pop, valid_o=0.
//   FWD:  req_o=route reg held. Transfer when grant_i & out_ready_i & !empty_i:
//         valid_o=1, flit_o=data_i, read_o=1 same cycle. Otherwise valid_o=0, read_o=0, flit_o=0.
//         Transfer of TAIL or HEAD_TAIL -> IDLE next cycle (req_o drops next cycle).
//         Transfer of HEAD while in FWD (malformed, previous packet lacked tail): forwarded,
//         stay FWD, route not re-latched.
//  Latency: head visible at cycle 0 -> req_o cycle 1 -> grant at cycle g -> head on flit_o
//   at cycle g+1 (if ready & buffer non-empty); then one flit/cycle back-to-back.
//  Next packet: head appearing the cycle after a tail is seen in IDLE; min 3 cycles
//   between tail transfer and next head transfer (IDLE, REQ, grant).
//  Buffer empty mid-packet: stall in FWD, req_o held, no bubble flits emitted.
//  grant_i dropped in FWD: stall, no pop, stay FWD. grant_i ignored in IDLE.
//  read_o never asserted when empty_i=1. flit_o and valid_o purely combinational; no storage.
//  Reset mid-packet: FSM to IDLE, request released; remaining flits are not purged here.
// TESTING
//  1 CUR=(1,1); head dest (3,1), body, tail; grant 2 cyc after req -> req_o=00010 (EAST),
//    3 flits on flit_o consecutive cycles, read_o=3 pulses, req_o=0 after tail.
//  2 CUR=(1,1); HEAD_TAIL dest (1,1) -> req_o=10000 (LOCAL); single transfer, back to IDLE.
//  3 Dest (1,0) and (0,2) from CUR=(1,1) -> SOUTH 00100, WEST 01000; dest (1,3) -> NORTH 00001.
//  4 4-flit packet, out_ready_i low for 2 cycles mid-packet and buffer empty 1 cycle ->
//    valid_o=0, read_o=0 during stalls, no flit lost or duplicated, order preserved.
//  5 BODY flit at buffer head while IDLE -> read_o=1 one cycle, err_o pulse, req_o stays 0.
//  6 rst=0 asynchronously in FWD after 2 of 4 flits -> req_o, valid_o, read_o 0 at once;
//    after release, FSM in IDLE.

Source files
------------

// File: rtl/route_compute_unit.sv
// Per-input-port route computation: XY-routes the head flit, requests the output
// port from the switch allocator, then streams the packet to the crossbar until its tail.
module route_compute_unit #(
  parameter int FLIT_SIZE = 16,
  parameter int COORD_W   = 2,
  parameter int CUR_X     = 0,
  parameter int CUR_Y     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 empty_i,
  output logic                 read_o,
  output logic [4:0]           req_o,
  input  logic                 grant_i,
  input  logic                 out_ready_i,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 valid_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {IDLE, REQ, FWD} state_t;

  // Port one-hot order is {LOCAL,WEST,SOUTH,EAST,NORTH}
  localparam logic [4:0] P_NORTH = 5'b00001;
  localparam logic [4:0] P_EAST  = 5'b00010;
  localparam logic [4:0] P_SOUTH = 5'b00100;
  localparam logic [4:0] P_WEST  = 5'b01000;
  localparam logic [4:0] P_LOCAL = 5'b10000;

  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

  state_t               state_q, state_d;
  logic [4:0]           route_q, route_d;
  logic                 err_q, err_d;

  logic [1:0]           flit_type;
  logic                 is_head, is_tail;
  logic [COORD_W-1:0]   dest_x, dest_y;
  logic [4:0]           route_calc;
  logic                 xfer, drop;

  // Type bit 0 marks a head (HEAD/HEAD_TAIL), bit 1 marks a tail (TAIL/HEAD_TAIL)
  assign flit_type = data_i[FLIT_SIZE-1 -: 2];
  assign is_head   = flit_type[0];
  assign is_tail   = flit_type[1];
  assign dest_x    = data_i[FLIT_SIZE-3 -: COORD_W];
  assign dest_y    = data_i[FLIT_SIZE-3-COORD_W -: COORD_W];

  always_comb begin
    if (dest_x > CX)      route_calc = P_EAST;
    else if (dest_x < CX) route_calc = P_WEST;
    else if (dest_y > CY) route_calc = P_NORTH;
    else if (dest_y < CY) route_calc = P_SOUTH;
    else                  route_calc = P_LOCAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      route_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_i) begin
          if (is_head) begin
            route_d = route_calc;
            state_d = REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ:     if (grant_i) state_d = FWD;
      // A stray head inside a packet is forwarded; only a tail closes the packet
      FWD:     if (xfer && is_tail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by reset so they fall the instant reset asserts
  always_comb begin
    xfer    = rst && (state_q == FWD) && grant_i && out_ready_i && !empty_i;
    drop    = rst && (state_q == IDLE) && !empty_i && !is_head;
    req_o   = (state_q == IDLE) ? 5'b0 : route_q;
    read_o  = xfer || drop;
    valid_o = xfer;
    flit_o  = xfer ? data_i : '0;
    err_o   = err_q;
  end

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit at CUR=(1,1): a queue-backed buffer model feeds the DUT,
// a packet-level model predicts every output each cycle, directed cases pin literals.
module tb_route_compute_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_i;
  logic        empty_i;
  logic        read_o;
  logic [4:0]  req_o;
  logic        grant_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [15:0] flit_o;
  logic        valid_o;
  logic        err_o;

  route_compute_unit #(.FLIT_SIZE(16), .COORD_W(2), .CUR_X(1), .CUR_Y(1)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .empty_i(empty_i), .read_o(read_o),
    .req_o(req_o), .grant_i(grant_i), .out_ready_i(out_ready_i), .flit_o(flit_o),
    .valid_o(valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HT = 2'b11;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] buf_q[$];
  logic [15:0] got[$];
  bit          hide = 1'b0;
  bit          pop_seen = 1'b0;

  // Packet-level model: a header has been accepted / the allocator has granted it
  bit          m_pkt = 0, m_gr = 0, m_err = 0;
  logic [4:0]  m_rt = '0;
  bit          n_pkt = 0, n_gr = 0, n_err = 0;
  logic [4:0]  n_rt = '0;

  function automatic logic [15:0] mk(logic [1:0] t, int dx, int dy, int pl);
    return {t, 2'(dx), 2'(dy), 10'(pl)};
  endfunction

  function automatic logic [4:0] route_of(logic [15:0] f);
    int dx = int'(f[13:12]);
    int dy = int'(f[11:10]);
    if (dx > 1) return 5'b00010;
    if (dx < 1) return 5'b01000;
    if (dy > 1) return 5'b00001;
    if (dy < 1) return 5'b00100;
    return 5'b10000;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply();
    empty_i = hide || (buf_q.size() == 0);
    data_i  = empty_i ? 16'($urandom) : buf_q[0];
  endtask

  task automatic model_reset();
    m_pkt = 0; m_gr = 0; m_err = 0; m_rt = '0;
    n_pkt = 0; n_gr = 0; n_err = 0; n_rt = '0;
  endtask

  // Per-cycle compare of every output against the model
  task automatic mdl_cmp();
    logic [1:0] t;
    bit hd, tl, xf, dr;
    logic [4:0] e_req;
    t  = data_i[15:14];
    hd = (t == HEAD) || (t == HT);
    tl = (t == TAIL) || (t == HT);
    if (!rst) begin
      chk("rst req", {11'b0, req_o}, 16'h0);
      chk("rst valid", {15'b0, valid_o}, 16'h0);
      chk("rst read", {15'b0, read_o}, 16'h0);
      chk("rst flit", flit_o, 16'h0);
      chk("rst err", {15'b0, err_o}, 16'h0);
      pop_seen = 0;
      model_reset();
      return;
    end
    e_req = m_pkt ? m_rt : 5'b0;
    xf = m_gr && grant_i && out_ready_i && !empty_i;
    dr = !m_pkt && !empty_i && !hd;
    chk("req", {11'b0, req_o}, {11'b0, e_req});
    chk("valid", {15'b0, valid_o}, {15'b0, xf});
    chk("read", {15'b0, read_o}, {15'b0, xf || dr});
    chk("flit", flit_o, xf ? data_i : 16'h0);
    chk("err", {15'b0, err_o}, {15'b0, m_err});
    pop_seen = read_o;
    if (valid_o) got.push_back(flit_o);
    n_pkt = m_pkt; n_gr = m_gr; n_rt = m_rt; n_err = dr;
    if (!m_pkt && !empty_i && hd) begin n_pkt = 1; n_rt = route_of(data_i); end
    if (m_pkt && !m_gr && grant_i) n_gr = 1;
    if (xf && tl) begin n_pkt = 0; n_gr = 0; end
  endtask

  task automatic cyc();
    @(negedge clk);
    mdl_cmp();
    @(posedge clk);
    if (rst) begin m_pkt = n_pkt; m_gr = n_gr; m_rt = n_rt; m_err = n_err; end
    else model_reset();
    #1;
    if (pop_seen && buf_q.size() > 0) void'(buf_q.pop_front());
    pop_seen = 0;
    apply();
  endtask

  logic [15:0] exp_f[$];
  int          dxs[5] = '{1, 1, 0, 1, 3};
  int          dys[5] = '{1, 0, 2, 3, 1};
  logic [4:0]  prs[5] = '{5'b10000, 5'b00100, 5'b01000, 5'b00001, 5'b00010};

  initial begin
    // Reset state
    apply();
    #3;
    chk("reset req", {11'b0, req_o}, 16'h0);
    chk("reset valid", {15'b0, valid_o}, 16'h0);
    chk("reset read", {15'b0, read_o}, 16'h0);
    chk("reset flit", flit_o, 16'h0);
    chk("reset err", {15'b0, err_o}, 16'h0);
    cyc(); cyc();
    rst = 1'b1;

    // 1: three-flit packet to EAST, grant two cycles after the request
    grant_i = 0; out_ready_i = 1;
    buf_q.push_back(mk(HEAD, 3, 1, 1));
    buf_q.push_back(mk(BODY, 0, 0, 2));
    buf_q.push_back(mk(TAIL, 0, 0, 3));
    apply(); #1;
    chk("t1 idle req", {11'b0, req_o}, 16'h0);
    cyc(); #1;
    chk("t1 req east", {11'b0, req_o}, 16'h0002);
    cyc();
    cyc(); grant_i = 1;
    cyc(); #1;
    chk("t1 head valid", {15'b0, valid_o}, 16'h1);
    chk("t1 head flit", flit_o, 16'h7401);
    chk("t1 head read", {15'b0, read_o}, 16'h1);
    cyc(); #1;
    chk("t1 body flit", flit_o, 16'h0002);
    cyc(); #1;
    chk("t1 tail flit", flit_o, 16'h8003);
    cyc(); #1;
    chk("t1 req dropped", {11'b0, req_o}, 16'h0);
    chk("t1 idle valid", {15'b0, valid_o}, 16'h0);

    // 2/3: single-flit packets exercising every output port
    for (int i = 0; i < 5; i++) begin
      grant_i = 0;
      buf_q.push_back(mk(HT, dxs[i], dys[i], 100 + i));
      apply();
      cyc(); #1;
      chk("t3 route", {11'b0, req_o}, {11'b0, prs[i]});
      grant_i = 1;
      cyc(); #1;
      chk("t3 single xfer", {15'b0, valid_o}, 16'h1);
      cyc(); #1;
      chk("t3 back idle", {11'b0, req_o}, 16'h0);
    end

    // 4: stalls from an empty buffer and from backpressure
    grant_i = 1; out_ready_i = 1; got.delete();
    buf_q.push_back(mk(HEAD, 2, 0, 40));
    buf_q.push_back(mk(BODY, 0, 0, 41));
    apply();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 5) begin
        buf_q.push_back(mk(BODY, 0, 0, 42));
        buf_q.push_back(mk(TAIL, 0, 0, 43));
        apply();
      end
      out_ready_i = !(k == 6 || k == 7);
      #1;
      if (k == 4) chk("t4 empty stall", {15'b0, valid_o}, 16'h0);
      if (k == 6) begin
        chk("t4 ready stall valid", {15'b0, valid_o}, 16'h0);
        chk("t4 ready stall read", {15'b0, read_o}, 16'h0);
        chk("t4 stall req held", {11'b0, req_o}, 16'h0002);
      end
    end
    exp_f = '{16'h6028, 16'h0029, 16'h002a, 16'h802b};
    chk("t4 flit count", 16'(got.size()), 16'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t4 order", got[i], exp_f[i]);

    // 5: stray body flit while idle
    grant_i = 0;
    buf_q.push_back(mk(BODY, 0, 0, 7));
    apply(); #1;
    chk("t5 drop read", {15'b0, read_o}, 16'h1);
    chk("t5 no req", {11'b0, req_o}, 16'h0);
    cyc(); #1;
    chk("t5 err pulse", {15'b0, err_o}, 16'h1);
    chk("t5 read done", {15'b0, read_o}, 16'h0);
    cyc(); #1;
    chk("t5 err over", {15'b0, err_o}, 16'h0);

    // 6: asynchronous reset in the middle of a four-flit packet
    grant_i = 1; out_ready_i = 1; got.delete();
    buf_q.push_back(mk(HEAD, 0, 1, 60));
    for (int i = 61; i < 63; i++) buf_q.push_back(mk(BODY, 0, 0, i));
    buf_q.push_back(mk(TAIL, 0, 0, 63));
    apply();
    for (int k = 0; k < 12 && got.size() < 2; k++) cyc();
    chk("t6 two sent", 16'(got.size()), 16'd2);
    #1;
    chk("t6 pre valid", {15'b0, valid_o}, 16'h1);
    #1 rst = 1'b0;
    #1;
    chk("t6 req at once", {11'b0, req_o}, 16'h0);
    chk("t6 valid at once", {15'b0, valid_o}, 16'h0);
    chk("t6 read at once", {15'b0, read_o}, 16'h0);
    model_reset();
    cyc();
    rst = 1'b1; grant_i = 0; #1;
    chk("t6 idle req", {11'b0, req_o}, 16'h0);
    chk("t6 idle valid", {15'b0, valid_o}, 16'h0);
    for (int k = 0; k < 4; k++) cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (buf_q.size() < 3) begin
        int r = $urandom_range(0, 29);
        int dx = $urandom_range(0, 3);
        int dy = $urandom_range(0, 3);
        if (r == 0) buf_q.push_back(mk(BODY, 0, 0, $urandom_range(0, 1023)));
        else if (r == 1) begin
          buf_q.push_back(mk(HEAD, dx, dy, $urandom_range(0, 1023)));
          buf_q.push_back(mk(BODY, 0, 0, $urandom_range(0, 1023)));
        end else begin
          int len = $urandom_range(1, 5);
          if (len == 1) buf_q.push_back(mk(HT, dx, dy, $urandom_range(0, 1023)));
          else begin
            buf_q.push_back(mk(HEAD, dx, dy, $urandom_range(0, 1023)));
            for (int j = 0; j < len - 2; j++) buf_q.push_back(mk(BODY, 0, 0, $urandom_range(0, 1023)));
            buf_q.push_back(mk(TAIL, 0, 0, $urandom_range(0, 1023)));
          end
        end
      end
      hide        = ($urandom_range(0, 4) == 0);
      grant_i     = ($urandom_range(0, 6) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      apply();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
